// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - shared types and defaults for the HC-SR04 echo emulator
//
// Purpose : FSM state encoding, timing defaults shared with the ranging
//           controller, and the Echo width counter size.
// Ports   : none (package)
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam int unsigned CYC_PER_CM_DEF   = 2941;
  localparam int unsigned TRIG_MIN_CYC_DEF = 500;
  localparam int unsigned TIMEOUT_CYC_DEF  = 1900000;
  localparam int unsigned ECHO_W_WIDTH     = 21;

endpackage

// File: rtl/hcsr04_echo_emulator_bcd16_to_bin.sv
// rtl/hcsr04_echo_emulator_bcd16_to_bin.sv - 4-digit BCD to 14-bit binary
//
// Purpose : combinational BCD to binary conversion with digit-invalid flag.
// Ports   : i_bcd     [15:0] four BCD digits, digit 3 in bits [15:12]
//           o_bin     [13:0] binary value (meaningless when o_invalid=1)
//           o_invalid        any digit greater than 9
module bcd16_to_bin (
  input  logic [15:0] i_bcd,
  output logic [13:0] o_bin,
  output logic        o_invalid
);

  logic [3:0] w_d3, w_d2, w_d1, w_d0;

  assign w_d3 = i_bcd[15:12];
  assign w_d2 = i_bcd[11:8];
  assign w_d1 = i_bcd[7:4];
  assign w_d0 = i_bcd[3:0];

  assign o_invalid = (w_d3 > 4'd9) | (w_d2 > 4'd9) | (w_d1 > 4'd9) | (w_d0 > 4'd9);

  assign o_bin = 14'(w_d3) * 14'd1000 + 14'(w_d2) * 14'd100
               + 14'(w_d1) * 14'd10   + 14'(w_d0);

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// rtl/hcsr04_echo_emulator.sv - HC-SR04 responder model (Trig in, Echo out)
//
// Purpose : validates the Trig pulse width, waits the burst delay, then drives
//           Echo for bin(dist_bcd)*CYC_PER_CM + ECHO_PAD cycles (TIMEOUT_CYC
//           for invalid/out-of-range distances), followed by a hold-off.
// Macro   : HCSR04_JITTER_EN adds 0..255 cycles of LFSR jitter to valid widths.
// Ports   : CLK_50M     system clock
//           RST         asynchronous active-low reset
//           Trig        asynchronous trigger input
//           dist_bcd    [15:0] distance in cm, 4 BCD digits
//           Echo        emulated echo pulse
//           busy        FSM not in IDLE
//           trig_short  one-cycle pulse on a rejected short trigger
//           range_err   latched distance invalid or above MAX_CM
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int unsigned CYC_PER_CM    = CYC_PER_CM_DEF,
  parameter int unsigned ECHO_PAD      = 1470,
  parameter int unsigned TRIG_MIN_CYC  = TRIG_MIN_CYC_DEF,
  parameter int unsigned BURST_DLY_CYC = 10000,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC   = 50000
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        Trig,
  input  logic [15:0] dist_bcd,
  output logic        Echo,
  output logic        busy,
  output logic        trig_short,
  output logic        range_err
);

  localparam int unsigned CNT_MAX_A = (BURST_DLY_CYC > HOLDOFF_CYC) ? BURST_DLY_CYC : HOLDOFF_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TRIG_MIN_CYC) ? CNT_MAX_A : TRIG_MIN_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  logic                    r_trig_s1, r_trig_s2, r_trig_d;
  logic                    w_rise, w_fall;
  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [ECHO_W_WIDTH-1:0] r_echo_w, w_echo_w_nxt;
  logic                    r_trig_short, w_trig_short_nxt;
  logic                    r_range_err, w_range_err_nxt;
  logic [13:0]             w_bin;
  logic                    w_bcd_bad, w_dist_bad;
  logic [ECHO_W_WIDTH-1:0] w_jitter, w_width;

  bcd16_to_bin u_bcd (
    .i_bcd     (dist_bcd),
    .o_bin     (w_bin),
    .o_invalid (w_bcd_bad)
  );

`ifdef HCSR04_JITTER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) r_lfsr <= 16'hACE1;
    else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
  end

  assign w_jitter = ECHO_W_WIDTH'(r_lfsr[7:0]);
`else
  assign w_jitter = '0;
`endif

  assign w_dist_bad = w_bcd_bad | (32'(w_bin) > MAX_CM);
  assign w_width    = w_dist_bad ? ECHO_W_WIDTH'(TIMEOUT_CYC)
                                 : ECHO_W_WIDTH'(32'(w_bin) * CYC_PER_CM + ECHO_PAD) + w_jitter;

  assign w_rise = r_trig_s2 & ~r_trig_d;
  assign w_fall = ~r_trig_s2 & r_trig_d;

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      r_trig_s1    <= 1'b0;
      r_trig_s2    <= 1'b0;
      r_trig_d     <= 1'b0;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_echo_w     <= '0;
      r_trig_short <= 1'b0;
      r_range_err  <= 1'b0;
    end else begin
      r_trig_s1    <= Trig;
      r_trig_s2    <= r_trig_s1;
      r_trig_d     <= r_trig_s2;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_echo_w     <= w_echo_w_nxt;
      r_trig_short <= w_trig_short_nxt;
      r_range_err  <= w_range_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_echo_w_nxt     = r_echo_w;
    w_trig_short_nxt = 1'b0;
    w_range_err_nxt  = r_range_err;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = TRIG_HI;
          w_cnt_nxt   = '0;
        end
      end
      TRIG_HI: begin
        // The rise-detect cycle is itself a high cycle, so a pulse of N
        // synchronized high cycles leaves r_cnt at N-1 when the fall is seen.
        if (w_fall) begin
          if (r_cnt >= CNT_W'(TRIG_MIN_CYC - 1)) begin
            w_state_nxt     = BURST;
            w_cnt_nxt       = '0;
            w_echo_w_nxt    = w_width;
            w_range_err_nxt = w_dist_bad;
          end else begin
            w_state_nxt      = IDLE;
            w_trig_short_nxt = 1'b1;
          end
        end else if (r_cnt < CNT_W'(TRIG_MIN_CYC)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      BURST: begin
        if (r_cnt == CNT_W'(BURST_DLY_CYC - 1)) begin
          w_state_nxt = ECHO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ECHO: begin
        // Loaded with W, leaves after the cycle showing 1: W high cycles.
        if (r_echo_w <= ECHO_W_WIDTH'(1)) begin
          w_state_nxt = HOLDOFF;
          w_cnt_nxt   = '0;
        end else begin
          w_echo_w_nxt = r_echo_w - ECHO_W_WIDTH'(1);
        end
      end
      HOLDOFF: begin
        if (r_cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decoded from the state register so an asynchronous reset drops Echo at once.
  assign Echo       = (r_state == ECHO);
  assign busy       = (r_state != IDLE);
  assign trig_short = r_trig_short;
  assign range_err  = r_range_err;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb/tb_hcsr04_echo_emulator.sv - directed self-checking bench for hcsr04_echo_emulator
module tb_hcsr04_echo_emulator;

  localparam int unsigned T_CYC_PER_CM = 7;
  localparam int unsigned T_PAD        = 3;
  localparam int unsigned T_TRIG_MIN   = 10;
  localparam int unsigned T_BURST      = 20;
  localparam int unsigned T_TIMEOUT    = 4000;
  localparam int unsigned T_HOLDOFF    = 60;
  // Trig pin drop to first Echo-high negedge: 3 cycles sync/detect + BURST + 1.
  localparam int unsigned T_LAT        = T_BURST + 4;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [15:0] dist_bcd;
  logic        echo;
  logic        busy;
  logic        trig_short;
  logic        range_err;

  int n_checks;
  int n_fail;

  hcsr04_echo_emulator #(
    .CYC_PER_CM    (T_CYC_PER_CM),
    .ECHO_PAD      (T_PAD),
    .TRIG_MIN_CYC  (T_TRIG_MIN),
    .BURST_DLY_CYC (T_BURST),
    .MAX_CM        (400),
    .TIMEOUT_CYC   (T_TIMEOUT),
    .HOLDOFF_CYC   (T_HOLDOFF)
  ) dut (
    .CLK_50M    (clk),
    .RST        (rst_n),
    .Trig       (trig),
    .dist_bcd   (dist_bcd),
    .Echo       (echo),
    .busy       (busy),
    .trig_short (trig_short),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Trig held high for n rising edges; returns just after the edge where it drops.
  task automatic pulse_trig(input int n);
    @(posedge clk); #1 trig = 1'b1;
    repeat (n) @(posedge clk);
    #1 trig = 1'b0;
  endtask

  task automatic wait_rise(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!echo && lat < 200);
  endtask

  task automatic measure_echo(output int lat, output int wid);
    wait_rise(lat);
    wid = 0;
    while (echo && wid < 10000) begin
      wid++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] bcd;
    int          width;
    int          err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, wid, cnt_ts, cnt_echo;
    n_checks = 0;
    n_fail   = 0;
    trig     = 1'b0;
    dist_bcd = 16'h0000;
    rst_n    = 1'b0;
    vecs[0] = '{16'h0123, 123 * 7 + 3, 0};
    vecs[1] = '{16'h0401, 4000, 1};
    vecs[2] = '{16'h00A5, 4000, 1};
    vecs[3] = '{16'h0000, 3, 0};
    vecs[4] = '{16'h0001, 10, 0};
    vecs[5] = '{16'h0400, 2803, 0};

    repeat (3) @(negedge clk);
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_trig_short", int'(trig_short), 0);
    check("rst_range_err", int'(range_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      dist_bcd = vecs[i].bcd;
      pulse_trig(T_TRIG_MIN);
      measure_echo(lat, wid);
      check($sformatf("lat_%04h", vecs[i].bcd), lat, T_LAT);
      check($sformatf("width_%04h", vecs[i].bcd), wid, vecs[i].width);
      check($sformatf("range_err_%04h", vecs[i].bcd), int'(range_err), vecs[i].err);
      repeat (T_HOLDOFF + 10) @(negedge clk);
      check($sformatf("idle_%04h", vecs[i].bcd), int'(busy), 0);
    end

    // Short trigger: one-cycle trig_short, no Echo, back to idle.
    dist_bcd = 16'h0123;
    pulse_trig(T_TRIG_MIN - 1);
    cnt_ts   = 0;
    cnt_echo = 0;
    repeat (40) begin
      @(negedge clk);
      if (trig_short) cnt_ts++;
      if (echo) cnt_echo++;
    end
    check("short_pulse_count", cnt_ts, 1);
    check("short_no_echo", cnt_echo, 0);
    check("short_busy", int'(busy), 0);

    // Trigger during HOLDOFF is dropped; the next one after HOLDOFF is taken.
    dist_bcd = 16'h0010;
    pulse_trig(T_TRIG_MIN);
    measure_echo(lat, wid);
    check("ho_first_width", wid, 73);
    pulse_trig(T_TRIG_MIN + 2);
    cnt_echo = 0;
    repeat (100) begin
      @(negedge clk);
      if (echo) cnt_echo++;
    end
    check("ho_ignored", cnt_echo, 0);
    pulse_trig(T_TRIG_MIN);
    measure_echo(lat, wid);
    check("ho_next_lat", lat, T_LAT);
    check("ho_next_width", wid, 73);
    repeat (T_HOLDOFF + 10) @(negedge clk);

    // Reset in the middle of Echo, then a normal full-width pulse.
    dist_bcd = 16'h0123;
    pulse_trig(T_TRIG_MIN);
    wait_rise(lat);
    check("mid_rst_rise", int'(echo), 1);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_echo", int'(echo), 0);
    check("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_trig(T_TRIG_MIN);
    measure_echo(lat, wid);
    check("post_rst_lat", lat, T_LAT);
    check("post_rst_width", wid, 864);
    check("post_rst_range_err", int'(range_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hcsr04_echo_emulator.md
Name: hcsr04_echo_emulator

Overview:
Responder-side model of an HC-SR04 ultrasonic ranging sensor. It watches the Trig line from the ranging controller, validates the trigger pulse width, waits a fixed burst delay, then drives Echo high for a width proportional to a programmed BCD distance in centimetres. It is used for hardware-in-the-loop bring-up and closed-loop verification of the ranging controller on the 50 MHz board clock.

Parameters:
CYC_PER_CM, 2941, Echo cycles per centimetre; matches the controller's 2941-cycle count tick.
ECHO_PAD, 1470, extra Echo cycles added to every valid pulse, so the controller's truncating count lands mid-bin.
TRIG_MIN_CYC, 500, minimum synchronized Trig high width in cycles (10 us).
BURST_DLY_CYC, 10000, cycles from accepted Trig fall to Echo rise (200 us).
MAX_CM, 400, largest in-range distance.
TIMEOUT_CYC, 1900000, Echo width for out-of-range or invalid distance (38 ms).
HOLDOFF_CYC, 50000, dead time after Echo falls before a new Trig is accepted.

Ports:
CLK_50M  in  1  system clock, 50 MHz
RST  in  1  asynchronous, active-low reset
Trig  in  1  trigger from the ranging controller; asynchronous, 2-FF synchronized internally
dist_bcd  in  16  programmed distance, 4 BCD digits, cm; sampled once per accepted trigger
Echo  out  1  emulated echo pulse
busy  out  1  high in any state other than IDLE
trig_short  out  1  one-cycle pulse when a Trig high shorter than TRIG_MIN_CYC is rejected
range_err  out  1  registered; set when the latched distance is invalid or above MAX_CM; updated on each accepted trigger

Behaviour:
- Reset (RST low, async): Echo=0, busy=0, trig_short=0, range_err=0, state=IDLE, all counters=0, sync flops=0. Reset asserted mid-Echo drops Echo in the same cycle.
- Trig passes through a 2-FF synchronizer plus an edge register. Rise and fall are detected on the synchronized signal, so there are 2-3 cycles of latency from the pin.
- IDLE: on synchronized rise, go to TRIG_HI and clear the width counter.
- TRIG_HI: increment the width counter, saturating at TRIG_MIN_CYC. On fall:
  - Count >= TRIG_MIN_CYC: latch dist_bcd, compute the width (below) and go to BURST.
  - Otherwise: pulse trig_short for 1 cycle and return to IDLE.
- BURST: count BURST_DLY_CYC cycles. Echo rises on the first cycle of ECHO, which is exactly BURST_DLY_CYC+1 cycles after the fall-detect cycle.
- ECHO: Echo=1 and a 21-bit down-counter runs. Echo falls on the cycle after the counter reaches 1, giving exactly W high cycles. Then go to HOLDOFF.
- HOLDOFF: Echo=0 for HOLDOFF_CYC cycles, then IDLE.
- Trig edges in BURST, ECHO or HOLDOFF are ignored. A Trig already high when IDLE is re-entered is not accepted; a fresh rise is required.
- Width rule: W = bin(dist_bcd)*CYC_PER_CM + ECHO_PAD.
  - Any BCD digit > 9, or bin > MAX_CM: W = TIMEOUT_CYC and range_err=1.
  - Distance 0: W = ECHO_PAD.
  - All widths fit in 21 bits (400*2941+1470 = 1177870; 1900000 < 2^21).
- The multiply is performed once, in the latch cycle: a constant multiply, registered.
- A timeout-width pulse exceeds the controller's 1000001-cycle trigger period. The next trigger lands in ECHO or HOLDOFF and is dropped; this is required behaviour.

Optional Feature:
HCSR04_JITTER_EN.
- Defined: a 16-bit maximal LFSR (taps 16,15,13,4, seed 16'hACE1 on reset) advances every cycle. Its low 8 bits are added to W at latch time, giving 0..255 cycles of width jitter. This never applies to TIMEOUT_CYC.
- Undefined: no LFSR; W is deterministic.

Decomposition:
- Package hcsr04_pkg holds:
  - the state enum (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF), 3 bits
  - CYC_PER_CM, TRIG_MIN_CYC and TIMEOUT_CYC defaults, shared with the ranging controller
  - ECHO_W_WIDTH=21
- One sub-module: bcd16_to_bin. Combinational 4-digit BCD to 14-bit binary with a digit-invalid flag, reusable by display logic.

Test Plan:
- dist_bcd=16'h0123, Trig high 500 cycles -> Echo rises 10001 cycles after fall detect; Echo high 123*2941+1470 = 363213 cycles; range_err=0.
- Trig high 499 cycles -> trig_short single-cycle pulse, Echo stays 0, busy returns to 0.
- dist_bcd=16'h0401 and, separately, 16'h00A5 -> Echo high 1900000 cycles, range_err=1.
- Closed loop with the ranging controller, dist_bcd=16'h0250 -> controller data reads 16'h0250 after the second trigger; repeat with 0000, 0001 and 0400.
- Second Trig issued during HOLDOFF -> ignored, no Echo; next Trig after HOLDOFF is accepted.
- RST pulled low 1000 cycles into ECHO -> Echo=0 and busy=0 immediately; after release, a normal trigger produces a full-width pulse.
